// File: rtl/gemm_pkg.sv
// Shared types and default widths for the GeMM result writer.
package gemm_pkg;

  localparam int DefDataWidth = 32;
  localparam int DefAddrWidth = 16;
  localparam int DefFifoDepth = 4;

  // Writer job phases; exported on the debug port so checkers can follow the FSM.
  typedef enum logic [1:0] {
    WriterIdle,
    WriterActive,
    WriterDrain,
    WriterFinish
  } writer_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding result words between the datapath and the
// memory write port. Pointers carry one extra MSB so full and empty can be
// told apart when the index bits match.
//
// push is accepted when not full, or when full and a pop happens in the same
// cycle (the slot being read is freed at the same edge it is rewritten).
// pop is ignored when empty.
module result_fifo #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [PtrW:0]    wr_ptr;
  logic [PtrW:0]    rd_ptr;
  logic [Width-1:0] storage [Depth];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PtrW] != rd_ptr[PtrW]) &&
                    (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = storage[rd_ptr[PtrW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrOne;
      if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr[PtrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gemm_result_writer.sv
// Downstream stage of the GeMM controller: buffers result words in a small
// FIFO and writes them row-major to the C matrix in output SRAM.
//
// Write port handshake: mem_valid_o is high whenever the FIFO holds a word;
// a transfer happens on any cycle with mem_valid_o and mem_ready_i both high.
// While stalled, mem_addr_o and mem_wdata_o stay stable and mem_valid_o is
// never withdrawn (only reset can drop it). There is no backpressure toward
// the controller; a word arriving to a full FIFO is dropped and flagged.
module gemm_result_writer
  import gemm_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = DefAddrWidth,
  parameter int FifoDepth = DefFifoDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] ldc_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic                 result_valid_i,
  input  logic [DataWidth-1:0] result_data_i,
  input  logic                 ctrl_done_i,
  output logic                 mem_valid_o,
  input  logic                 mem_ready_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o,
  output logic                 mismatch_o,
  output writer_state_t        dbg_state_o,
  output logic [AddrWidth-1:0] dbg_row_o,
  output logic [AddrWidth-1:0] dbg_col_o
);

  localparam int WcWidth = 2 * AddrWidth;
  localparam logic [AddrWidth-1:0] AddrOne = 1;
  localparam logic [WcWidth-1:0]   WcOne   = 1;

  writer_state_t state;

  // Latched job configuration.
  logic [AddrWidth-1:0] ldc_q;
  logic [AddrWidth-1:0] m_size_q;
  logic [AddrWidth-1:0] n_size_q;

  // Address generation and write accounting.
  logic [AddrWidth-1:0] row_base;
  logic [AddrWidth-1:0] n_idx;
  logic [AddrWidth-1:0] m_idx;
  logic [WcWidth-1:0]   write_count;
  logic [WcWidth-1:0]   expected_total;
  logic                 n_last;

  // FIFO interface.
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DataWidth-1:0] fifo_head;
  logic                 xfer;

  // Results are captured only while a job is active, including the cycle
  // that carries ctrl_done_i.
  assign fifo_push = (state == WriterActive) && result_valid_i;
  assign xfer      = mem_valid_o && mem_ready_i;

  result_fifo #(
    .Width(DataWidth),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (fifo_push),
    .push_data(result_data_i),
    .pop      (xfer),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign mem_valid_o = !fifo_empty;
  assign mem_wdata_o = fifo_empty ? '0 : fifo_head;
  assign mem_addr_o  = row_base + n_idx;
  assign busy_o      = (state != WriterIdle);
  assign dbg_state_o = state;
  assign dbg_row_o   = m_idx;
  assign dbg_col_o   = n_idx;

  // Product widened to twice the address width so large jobs cannot wrap.
  assign expected_total = {{AddrWidth{1'b0}}, m_size_q} * {{AddrWidth{1'b0}}, n_size_q};

  // A zero column count never completes a row.
  assign n_last = (n_size_q != '0) && (n_idx == (n_size_q - AddrOne));

  // Config latch, row-major address walk and saturating write counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ldc_q       <= '0;
      m_size_q    <= '0;
      n_size_q    <= '0;
      row_base    <= '0;
      n_idx       <= '0;
      m_idx       <= '0;
      write_count <= '0;
    end else if ((state == WriterIdle) && start_i) begin
      ldc_q       <= ldc_i;
      m_size_q    <= M_size_i;
      n_size_q    <= N_size_i;
      row_base    <= base_addr_i;
      n_idx       <= '0;
      m_idx       <= '0;
      write_count <= '0;
    end else if (xfer) begin
      if (n_last) begin
        n_idx    <= '0;
        m_idx    <= m_idx + AddrOne;
        row_base <= row_base + ldc_q;
      end else begin
        n_idx <= n_idx + AddrOne;
      end
      if (write_count != '1) write_count <= write_count + WcOne;
    end
  end

  // Job FSM with registered done pulse and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= WriterIdle;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      mismatch_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        WriterIdle: begin
          if (start_i) begin
            overflow_o <= 1'b0;
            mismatch_o <= 1'b0;
            state      <= WriterActive;
          end
        end
        WriterActive: begin
          if (result_valid_i && fifo_full && !xfer) overflow_o <= 1'b1;
          if (ctrl_done_i) state <= WriterDrain;
        end
        WriterDrain: begin
          if (result_valid_i) overflow_o <= 1'b1;
          // An empty FIFO also means no write is outstanding on the port.
          if (fifo_empty) begin
            state      <= WriterFinish;
            done_o     <= 1'b1;
            mismatch_o <= (write_count != expected_total);
          end
        end
        WriterFinish: begin
          state <= WriterIdle;
        end
        default: begin
          state <= WriterIdle;
        end
      endcase
    end
  end

endmodule
